// File: rtl/seg_dynamic.sv
`timescale 1ns/1ps
// Time-multiplexed common-anode 7-segment driver with frame-aligned double buffering
// and optional leading-zero blanking.
module seg_dynamic #(
  parameter int unsigned      DIGITS   = 6,
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] SCAN_MAX = CNT_W'(49_999)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     point,
  input  logic                  data_vld,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  frame_tick,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] disp_data;
  logic [DIGITS-1:0] disp_point;
  logic [DATA_W-1:0] pend_data;
  logic [DIGITS-1:0] pend_point;

  logic              scan_wrap;
  logic              frame_end;
  logic              run;
  logic [DIGITS-1:0] tail_zero;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_blank;
  logic [7:0]        glyph;
  logic [7:0]        seg_nxt;

  // Hex glyphs with the decimal point off (bit 7 set).
  function automatic logic [7:0] font(input logic [3:0] nib);
    case (nib)
      4'h0:    font = 8'hc0;
      4'h1:    font = 8'hf9;
      4'h2:    font = 8'ha4;
      4'h3:    font = 8'hb0;
      4'h4:    font = 8'h99;
      4'h5:    font = 8'h92;
      4'h6:    font = 8'h82;
      4'h7:    font = 8'hf8;
      4'h8:    font = 8'h80;
      4'h9:    font = 8'h90;
      4'ha:    font = 8'h88;
      4'hb:    font = 8'h83;
      4'hc:    font = 8'hc6;
      4'hd:    font = 8'ha1;
      4'he:    font = 8'h86;
      default: font = 8'h8e;
    endcase
  endfunction

  // tail_zero[i]: every nibble and point from digit i upward is zero.
  always_comb begin
    scan_wrap = (cnt == SCAN_MAX);
    frame_end = scan_wrap && (idx == LAST_IDX);
    run       = 1'b1;
    tail_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run && (disp_data[4*i +: 4] == 4'd0) && !disp_point[i];
      tail_zero[i] = run;
    end
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = disp_data[4*i +: 4];
        cur_dp    = disp_point[i];
        cur_blank = blank_lz && (i != 0) && tail_zero[i];
      end
    end
    glyph   = font(cur_nib);
    seg_nxt = cur_blank ? 8'hff : {~cur_dp, glyph[6:0]};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      disp_data  <= '0;
      disp_point <= '0;
      pend_data  <= '0;
      pend_point <= '0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      sel        <= '0;
      seg        <= 8'hff;
    end else begin
      cnt        <= scan_wrap ? '0 : cnt + CNT_W'(1);
      if (scan_wrap) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      frame_tick <= frame_end;
      sel        <= DIGITS'(1) << idx;
      seg        <= seg_nxt;
      // A strobe coinciding with frame end bypasses the pending buffer.
      if (frame_end) begin
        if (data_vld) begin
          disp_data  <= data;
          disp_point <= point;
        end else if (busy) begin
          disp_data  <= pend_data;
          disp_point <= pend_point;
        end
        busy <= 1'b0;
      end else if (data_vld) begin
        pend_data  <= data;
        pend_point <= point;
        busy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_dynamic.sv
`timescale 1ns/1ps
// Directed bench for seg_dynamic with a 4-clock dwell (24-clock frame).
module tb_seg_dynamic;

  localparam int unsigned DIGITS = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0] point;
  logic              data_vld;
  logic              blank_lz;
  logic              busy;
  logic              frame_tick;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;

  int checks = 0;
  int errors = 0;
  int m      = 0;
  logic [7:0] exp_seg [DIGITS];

  seg_dynamic #(
    .DIGITS  (DIGITS),
    .CNT_W   (16),
    .SCAN_MAX(16'd3)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .data      (data),
    .point     (point),
    .data_vld  (data_vld),
    .blank_lz  (blank_lz),
    .busy      (busy),
    .frame_tick(frame_tick),
    .sel       (sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @%0d: observed %0h expected %0h", tag, m, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m++;
  endtask

  // Advance to edge count 'target', checking the scan outputs after every edge.
  task automatic run_to(input int target);
    int dig;
    while (m < target) begin
      step();
      dig = ((m - 1) / 4) % DIGITS;
      chk("sel", 32'(sel), 32'(1) << dig);
      chk("seg", 32'(seg), 32'(exp_seg[dig]));
      chk("frame_tick", 32'(frame_tick), 32'(m % 24 == 0));
    end
  endtask

  task automatic pulse(input logic [23:0] d, input logic [5:0] p, input int at);
    run_to(at);
    data     = d;
    point    = p;
    data_vld = 1'b1;
    run_to(at + 1);
    data_vld = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    data     = '0;
    point    = '0;
    data_vld = 1'b0;
    blank_lz = 1'b0;
    exp_seg  = '{8'hc0, 8'hc0, 8'hc0, 8'hc0, 8'hc0, 8'hc0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_seg", 32'(seg), 32'hff);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);

    // Plain scan of reset contents
    rst_n = 1'b1;
    m     = 0;
    run_to(24);

    // Mid-frame capture waits for frame end
    pulse(24'h12AB5F, 6'b000100, 30);
    chk("busy_set", 32'(busy), 32'h1);
    run_to(47);
    chk("busy_hold", 32'(busy), 32'h1);
    run_to(48);
    chk("busy_clr", 32'(busy), 32'h0);
    exp_seg = '{8'h8e, 8'h92, 8'h03, 8'h88, 8'ha4, 8'hf9};
    run_to(72);

    // Leading-zero blanking
    blank_lz = 1'b1;
    pulse(24'h000070, 6'b000000, 80);
    run_to(96);
    exp_seg = '{8'hc0, 8'hf8, 8'hff, 8'hff, 8'hff, 8'hff};
    pulse(24'h000070, 6'b001000, 100);
    run_to(120);
    exp_seg = '{8'hc0, 8'hf8, 8'hc0, 8'h40, 8'hff, 8'hff};
    run_to(144);

    // Last strobe wins; strobe in frame-end cycle commits directly
    pulse(24'h111111, 6'b000000, 150);
    pulse(24'h222222, 6'b000000, 155);
    chk("busy_ovr", 32'(busy), 32'h1);
    run_to(168);
    chk("busy_clr2", 32'(busy), 32'h0);
    exp_seg = '{8'ha4, 8'ha4, 8'ha4, 8'ha4, 8'ha4, 8'ha4};
    pulse(24'h333333, 6'b000000, 191);
    chk("busy_direct", 32'(busy), 32'h0);
    exp_seg = '{8'hb0, 8'hb0, 8'hb0, 8'hb0, 8'hb0, 8'hb0};
    run_to(200);

    // Reset with a pending value discards it
    pulse(24'h444444, 6'b000000, 202);
    chk("busy_pre_rst", 32'(busy), 32'h1);
    run_to(205);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_sel", 32'(sel), 32'h0);
    chk("rst2_seg", 32'(seg), 32'hff);
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_tick", 32'(frame_tick), 32'h0);
    rst_n    = 1'b1;
    blank_lz = 1'b0;
    m        = 0;
    exp_seg  = '{8'hc0, 8'hc0, 8'hc0, 8'hc0, 8'hc0, 8'hc0};
    run_to(48);
    chk("busy_after_rst", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
